// File: rtl/switch_arb_pkg.sv
// Shared types and constants for the switch request arbiter.
// SWITCH_ARB_FIXED_PRIORITY_EN selects fixed priority (highest switch wins) instead of round-robin.
package switch_arb_pkg;

    localparam int         NUM_REQ_DEFAULT = 18;
    localparam int         CNT_W           = 26;
    localparam int         IDX_W           = 5;
    localparam logic [3:0] BLANK_DIGIT     = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARBITRATE,
        S_HOLD
    } arb_state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair_t;

    // Switch numbers never exceed 19, so the tens digit is only ever 0 or 1.
    function automatic bcd_pair_t to_bcd(input logic [IDX_W-1:0] num);
        bcd_pair_t digits;
        if (num >= 5'd10) begin
            digits.tens = 4'd1;
            digits.ones = 4'(num - 5'd10);
        end else begin
            digits.tens = 4'd0;
            digits.ones = num[3:0];
        end
        return digits;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational winner search over the request vector, starting at a rotating pointer.
// With SWITCH_ARB_FIXED_PRIORITY_EN defined the pointer is ignored and the highest set bit wins.
module rr_priority_pick
    import switch_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

`ifdef SWITCH_ARB_FIXED_PRIORITY_EN

    logic unused_start;
    assign unused_start = ^start;

    // Ascending scan; the last hit is the highest-index request.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
    end

`else

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;

    // Upper copy is never masked, so requests below the pointer are reached after wrapping.
    assign dbl = {req, req};

    // NOTE: every output of a combinational block gets a default before any branch so no latch is inferred.
    always_comb begin
        masked = '0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < 2*NUM_REQ; i++) begin
            masked[i] = dbl[i] && (i >= int'(start));
        end
        // Descending scan; the last hit is the lowest masked position.
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (masked[i]) begin
                found  = 1'b1;
                winner = (i >= NUM_REQ) ? IDX_W'(i - NUM_REQ) : IDX_W'(i);
            end
        end
    end

`endif

endmodule

// File: rtl/switch_request_arbiter.sv
// Round-robin arbiter sharing the switch-number display among the toggle switches.
// SWITCH_ARB_FIXED_PRIORITY_EN (in rr_priority_pick) switches the winner search to fixed priority.
module switch_request_arbiter
    import switch_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEFAULT,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic               CLOCK_50_I,
    input  logic               RESET_I,
    input  logic               enable_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_valid_o,
    output logic [4:0]         grant_num_o,
    output logic [3:0]         bcd_tens_o,
    output logic [3:0]         bcd_ones_o,
    output logic               rotate_pulse_o
);

    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               hold_done;
    logic               load_grant;
    logic               clear_out;

    logic [NUM_REQ-1:0] grant_d;
    logic               valid_d;
    logic [4:0]         num_d;
    bcd_pair_t          bcd_d;
    logic               pulse_d;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_i),
        .start  (ptr_q),
        .found  (pick_found),
        .winner (pick_idx)
    );

    // Expiry and early release (granted request dropped) both end the hold.
    assign hold_done  = (cnt_q == HOLD_LAST) || ((grant_o & req_i) == '0);
    assign load_grant = enable_i && (state_q == S_ARBITRATE) && pick_found;
    assign clear_out  = (state_d == S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            cnt_q          <= '0;
            grant_o        <= '0;
            grant_valid_o  <= 1'b0;
            grant_num_o    <= '0;
            bcd_tens_o     <= BLANK_DIGIT;
            bcd_ones_o     <= BLANK_DIGIT;
            rotate_pulse_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            grant_o        <= grant_d;
            grant_valid_o  <= valid_d;
            grant_num_o    <= num_d;
            bcd_tens_o     <= bcd_d.tens;
            bcd_ones_o     <= bcd_d.ones;
            rotate_pulse_o <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      if (req_i != '0) state_d = S_ARBITRATE;
                S_ARBITRATE: state_d = pick_found ? S_HOLD : S_IDLE;
                S_HOLD:      if (hold_done) state_d = S_ARBITRATE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // Next values for the pointer, hold counter and registered outputs.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_o;
        valid_d = grant_valid_o;
        num_d   = grant_num_o;
        bcd_d   = '{tens: bcd_tens_o, ones: bcd_ones_o};
        pulse_d = 1'b0;

        if (state_q == S_HOLD) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (load_grant) begin
            ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            cnt_d   = '0;
            grant_d = ONE_HOT_0 << pick_idx;
            valid_d = 1'b1;
            num_d   = pick_idx + 1'b1;
            bcd_d   = to_bcd(pick_idx + 1'b1);
            pulse_d = 1'b1;
        end else if (clear_out) begin
            grant_d = '0;
            valid_d = 1'b0;
            num_d   = '0;
            bcd_d   = '{tens: BLANK_DIGIT, ones: BLANK_DIGIT};
        end
    end

endmodule

// File: tb/tb_switch_request_arbiter.sv
// Randomised and directed bench for switch_request_arbiter with a behavioural reference model.
// Honours SWITCH_ARB_FIXED_PRIORITY_EN when the design is built with it.
module tb_switch_request_arbiter;
    import switch_arb_pkg::*;

    localparam int N    = 18;
    localparam int HOLD = 4;
    localparam logic [N-1:0] ONE = N'(1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [N-1:0] req = '0;

    logic [N-1:0] grant;
    logic         grant_valid;
    logic [4:0]   grant_num;
    logic [3:0]   bcd_tens;
    logic [3:0]   bcd_ones;
    logic         rotate_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current grant (-1 = none), cycles spent in it, whether the
    // next edge re-arbitrates, the rotation pointer and the expected pulse.
    int m_cur     = -1;
    int m_held    = 0;
    int m_ptr     = 0;
    bit m_arb_due = 1'b0;
    bit m_pulse   = 1'b0;

    switch_request_arbiter #(
        .NUM_REQ     (N),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .CLOCK_50_I     (clk),
        .RESET_I        (rst),
        .enable_i       (en),
        .req_i          (req),
        .grant_o        (grant),
        .grant_valid_o  (grant_valid),
        .grant_num_o    (grant_num),
        .bcd_tens_o     (bcd_tens),
        .bcd_ones_o     (bcd_ones),
        .rotate_pulse_o (rotate_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
`ifdef SWITCH_ARB_FIXED_PRIORITY_EN
        for (int j = N-1; j >= 0; j--) if (r[j]) return j;
`else
        for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic model_step();
        int w;
        m_pulse = 1'b0;
        if (rst) begin
            m_cur = -1; m_held = 0; m_ptr = 0; m_arb_due = 1'b0;
        end else if (!en) begin
            m_cur = -1; m_arb_due = 1'b0;
        end else if (m_arb_due) begin
            m_arb_due = 1'b0;
            w = model_pick(req, m_ptr);
            if (w >= 0) begin
                m_cur = w; m_ptr = (w + 1) % N; m_held = 0; m_pulse = 1'b1;
            end else begin
                m_cur = -1;
            end
        end else if (m_cur >= 0) begin
            if (m_held == HOLD - 1 || !req[m_cur]) m_arb_due = 1'b1;
            m_held++;
        end else if (req != '0) begin
            m_arb_due = 1'b1;
        end
    endtask

    task automatic compare();
        logic [N-1:0] exp_grant;
        int num;
        bit act;
        act       = (m_cur >= 0);
        exp_grant = act ? (ONE << m_cur) : '0;
        num       = act ? m_cur + 1 : 0;
        check("grant", 32'(grant), 32'(exp_grant));
        check("valid", 32'(grant_valid), 32'(act));
        check("num", 32'(grant_num), 32'(num));
        check("tens", 32'(bcd_tens), act ? 32'(num / 10) : 32'(15));
        check("ones", 32'(bcd_ones), act ? 32'(num % 10) : 32'(15));
        check("pulse", 32'(rotate_pulse), 32'(m_pulse));
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        rst = 1'b1; en = 1'b1; req = r;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    initial begin
        int seq[$];
        int last_pulse;
        int first_after;

        // Reset latency with every switch requesting.
        do_reset(18'h3FFFF);
        cycle();
        check("lat_valid_1", 32'(grant_valid), 32'(0));
        check("lat_tens_1", 32'(bcd_tens), 32'(15));
        cycle();
        check("lat_valid_2", 32'(grant_valid), 32'(1));
`ifdef SWITCH_ARB_FIXED_PRIORITY_EN
        check("first_num", 32'(grant_num), 32'(18));
`else
        check("first_num", 32'(grant_num), 32'(1));
        check("first_ones", 32'(bcd_ones), 32'(1));
`endif
        repeat (10) cycle();

        // Rotation over switches 0, 5 and 17.
        do_reset(ONE | (ONE << 5) | (ONE << 17));
        seq = {};
        repeat (25) begin
            cycle();
            if (rotate_pulse) seq.push_back(int'(grant_num));
        end
        check("seq_len", 32'(seq.size() >= 4), 32'(1));
        if (seq.size() >= 4) begin
`ifdef SWITCH_ARB_FIXED_PRIORITY_EN
            for (int i = 0; i < 4; i++) check("seq_fixed", 32'(seq[i]), 32'(18));
`else
            check("seq_0", 32'(seq[0]), 32'(1));
            check("seq_1", 32'(seq[1]), 32'(6));
            check("seq_2", 32'(seq[2]), 32'(18));
            check("seq_3", 32'(seq[3]), 32'(1));
`endif
        end

        // Early release of switch 9 (number 10) while switch 12 appears.
        do_reset(ONE << 9);
        cycle(); cycle();
        check("rel_num", 32'(grant_num), 32'(10));
        check("rel_tens", 32'(bcd_tens), 32'(1));
        check("rel_ones", 32'(bcd_ones), 32'(0));
        cycle();
        req = ONE << 12;
        cycle();
        check("rel_hold_num", 32'(grant_num), 32'(10));
        cycle();
        check("rel_next_num", 32'(grant_num), 32'(13));
        check("rel_next_pulse", 32'(rotate_pulse), 32'(1));
        repeat (6) cycle();

        // Single requester: stable number, pulse every HOLD+1 cycles.
        do_reset(ONE << 3);
        last_pulse = -1;
        for (int c = 0; c < 22; c++) begin
            cycle();
            if (grant_valid) check("single_num", 32'(grant_num), 32'(4));
            if (rotate_pulse) begin
                if (last_pulse >= 0) check("single_period", 32'(c - last_pulse), 32'(HOLD + 1));
                last_pulse = c;
            end
        end

        // Enable dropped mid-hold, then resumed from the retained pointer.
        do_reset((ONE << 1) | (ONE << 7));
        repeat (4) cycle();
        en = 1'b0;
        cycle();
        check("dis_valid", 32'(grant_valid), 32'(0));
        check("dis_ones", 32'(bcd_ones), 32'(15));
        cycle();
        en = 1'b1;
        first_after = -1;
        repeat (6) begin
            cycle();
            if (rotate_pulse && first_after < 0) first_after = int'(grant_num);
        end
        check("reen_num", 32'(first_after), 32'(8));

        // Randomised traffic with occasional enable drops and resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req = '0;
                    1:       req = ONE << $urandom_range(0, N-1);
                    2:       req = N'($urandom) & N'($urandom) & N'($urandom);
                    default: req = N'($urandom);
                endcase
            end
            en  = ($urandom_range(0, 39) != 0);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_request_arbiter.md
Name: switch_request_arbiter

Overview:
- Round-robin arbiter that shares the switch-number display path among the 18 toggle switches, treated as requesters.
- Grants one asserted switch at a time for a programmable hold period, then rotates to the next asserted switch.
- Outputs a one-hot grant, the 1-based switch number, and two BCD digits that feed the hex-to-seven-segment converters (tens and ones).
- Sits between SWITCH_I and the display/LED logic in the top level.

Parameters:
- NUM_REQ, 18, number of requesters (switch lines).
- HOLD_CYCLES, 50000000, clock cycles a grant is held (1 s at 50 MHz); legal range 1 to 2^26-1.

Ports:
- CLOCK_50_I  input  1  system clock; all logic on rising edge.
- RESET_I  input  1  synchronous, active-high reset.
- enable_i  input  1  arbitration enable.
- req_i  input  NUM_REQ  request per switch; bit k is switch k.
- grant_o  output  NUM_REQ  one-hot grant; all zero when idle.
- grant_valid_o  output  1  a grant is active.
- grant_num_o  output  5  granted switch number, k+1 (range 1..18); 0 when idle.
- bcd_tens_o  output  4  tens digit of grant_num_o (0 or 1); 4'hF (blank) when idle.
- bcd_ones_o  output  4  ones digit of grant_num_o (0..9); 4'hF (blank) when idle.
- rotate_pulse_o  output  1  one-cycle pulse on every new grant.

Behaviour:
- Reset values:
  - state IDLE; rotation pointer 0; hold counter 0.
  - grant_o 0, grant_valid_o 0, grant_num_o 0, rotate_pulse_o 0.
  - bcd_tens_o and bcd_ones_o 4'hF.
- All outputs are registered.
- FSM states: IDLE, ARBITRATE, HOLD.
- IDLE:
  - Go to ARBITRATE when enable_i=1 and req_i != 0.
  - Otherwise stay, with outputs in their idle values.
- ARBITRATE (one cycle):
  - Winner = first set bit of req_i, searching ascending from the pointer and wrapping NUM_REQ-1 -> 0.
  - If a winner exists: register the grant outputs, pulse rotate_pulse_o, set pointer = (winner+1) mod NUM_REQ, clear the counter, go to HOLD.
  - If req_i is 0 (request withdrawn): go to IDLE with idle outputs.
- HOLD:
  - Counter increments each cycle.
  - Leave when counter = HOLD_CYCLES-1, or when req_i[granted] drops (early release).
  - On leaving: go to ARBITRATE; outputs hold their values until the next grant is registered.
  - Expiry and release in the same cycle behave identically (go to ARBITRATE).
- Latency:
  - req_i sampled in IDLE at edge n, then state ARBITRATE after edge n; grant_valid_o high after edge n+1 (2 cycles).
  - Grant duration is exactly HOLD_CYCLES+1 cycles, measured from the first grant cycle to the re-arbitration cycle, when not released.
- Single requester: re-granted after every hold; rotate_pulse_o fires each time; grant outputs stay stable.
- enable_i=0 in any state: next state IDLE, outputs cleared next cycle, pointer retained.
- RESET_I mid-HOLD: all registers return to reset values on that edge; pointer returns to 0.
- BCD conversion:
  - grant_num_o >= 10: tens=1, ones=grant_num_o-10.
  - Otherwise: tens=0, ones=grant_num_o.
- Counter width is 26 bits; HOLD_CYCLES=1 gives a one-cycle HOLD.

Optional Feature:
- Macro: SWITCH_ARB_FIXED_PRIORITY_EN.
- Defined:
  - The pointer is ignored; the winner is always the highest-index asserted switch (switch 17 dominates, down to switch 0).
  - Hold and release rules are unchanged.
  - A continuously held high switch starves lower ones.
- Undefined: round-robin as specified above.

Decomposition:
- Package switch_arb_pkg holds:
  - NUM_REQ_DEFAULT = 18.
  - BLANK_DIGIT = 4'hF.
  - arb_state_t enum {S_IDLE, S_ARBITRATE, S_HOLD}.
  - Counter width constant = 26.
- One combinational sub-module, rr_priority_pick:
  - Inputs: req vector and start pointer.
  - Outputs: found flag and 5-bit winner index.
  - Implementation: double-width masked search.
  - The fixed-priority variant is selected inside it under the macro.

Test Plan (bench uses HOLD_CYCLES=4):
- Reset with req_i=18'h3FFFF, enable_i=1 -> grant_valid_o=0, bcd digits 4'hF until 2 cycles after RESET_I deasserts; first grant is switch 0: grant_num_o=1, tens=0, ones=1.
- req_i bits 0,5,17 held -> grants cycle 1 -> 6 -> 18 -> 1, each lasting 5 cycles; for 18: tens=1, ones=8; rotate_pulse_o high once per grant.
- Grant on switch 9 (num 10), req_i[9] dropped mid-hold -> ARBITRATE next cycle, then next asserted switch granted; for num 10: tens=1, ones=0.
- Only req_i[3] held -> grant_num_o=4 stays stable across holds; rotate_pulse_o fires every 5 cycles.
- enable_i low during HOLD -> outputs idle next cycle; re-enable -> search resumes from the retained pointer.
- With SWITCH_ARB_FIXED_PRIORITY_EN, req_i bits 2 and 16 held -> grant_num_o always 17.
